// File: rtl/reg_file16.sv
// ============================================================================
// reg_file16 - operand register file feeding the 16-bit ALU
//
// Holds eight DATA_W-bit registers built from flops. The file has two
// independent combinational read ports (R and S) for the ALU operand buses
// and one synchronous write port for the ALU result. It also holds the
// N/Z/C status register and a saturating count of accepted writes.
//
// Ports:
//   clk               system clock, all state updates on the rising edge
//   reset_n           asynchronous active-low reset
//   W_En              register write enable
//   W_Addr            write address
//   W_Data            write data (ALU Y)
//   R_Addr, S_Addr    read addresses for ports R and S
//   R, S              read data to ALU operand buses
//   Flag_Ld           status register load enable
//   N_in, Z_in, C_in  flags from the ALU
//   N, Z, C           registered status flags
//   Wr_Count          saturating count of accepted writes (debug)
// ============================================================================
module reg_file16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              W_En,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [ADDR_W-1:0] R_Addr,
    input  logic [ADDR_W-1:0] S_Addr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    input  logic              Flag_Ld,
    input  logic              N_in,
    input  logic              Z_in,
    input  logic              C_in,
    output logic              N,
    output logic              Z,
    output logic              C,
    output logic [7:0]        Wr_Count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Register array. Reset wins over any write that is in flight, so a
    // register hit by reset is left at zero rather than at W_Data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (W_En) begin
            regs[W_Addr] <= W_Data;
        end
    end

    // Status flags load together and are never forwarded. They load
    // independently of the register write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            N <= 1'b0;
            Z <= 1'b0;
            C <= 1'b0;
        end else if (Flag_Ld) begin
            N <= N_in;
            Z <= Z_in;
            C <= C_in;
        end
    end

    // The write counter sticks at all-ones so that a long run never looks
    // like a quiet one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Wr_Count <= 8'h00;
        end else if (W_En && (Wr_Count != 8'hFF)) begin
            Wr_Count <= Wr_Count + 8'h01;
        end
    end

    // Read port R. When forwarding is enabled, a same-cycle write to the
    // addressed register appears right away. Outputs are forced to zero
    // while reset is held so that forwarding cannot leak W_Data.
    always_comb begin
        R = regs[R_Addr];
        if ((BYPASS != 0) && W_En && (W_Addr == R_Addr)) begin
            R = W_Data;
        end
        if (!reset_n) begin
            R = '0;
        end
    end

    // Read port S follows the same rules as port R.
    always_comb begin
        S = regs[S_Addr];
        if ((BYPASS != 0) && W_En && (W_Addr == S_Addr)) begin
            S = W_Data;
        end
        if (!reset_n) begin
            S = '0;
        end
    end

endmodule

// File: tb/tb_reg_file16.sv
// ============================================================================
// tb_reg_file16 - self-checking bench for reg_file16
//
// Drives two instances, one with forwarding and one without, from the same
// inputs. Their outputs are compared against a simple array/counter model of
// the register file. Directed scenarios come first, followed by a randomised
// run.
// ============================================================================
module tb_reg_file16;

    logic        clk;
    logic        reset_n;
    logic        W_En;
    logic [2:0]  W_Addr;
    logic [15:0] W_Data;
    logic [2:0]  R_Addr;
    logic [2:0]  S_Addr;
    logic        Flag_Ld;
    logic        N_in, Z_in, C_in;

    logic [15:0] r_byp, s_byp, r_nob, s_nob;
    logic        n_byp, z_byp, c_byp, n_nob, z_nob, c_nob;
    logic [7:0]  cnt_byp, cnt_nob;

    // Reference model: stored contents, flags and write count
    logic [15:0] mdl [8];
    logic        mdl_n, mdl_z, mdl_c;
    int          mdl_cnt;

    int checks;
    int errors;

    reg_file16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut_byp (
        .clk(clk), .reset_n(reset_n), .W_En(W_En), .W_Addr(W_Addr),
        .W_Data(W_Data), .R_Addr(R_Addr), .S_Addr(S_Addr), .R(r_byp),
        .S(s_byp), .Flag_Ld(Flag_Ld), .N_in(N_in), .Z_in(Z_in),
        .C_in(C_in), .N(n_byp), .Z(z_byp), .C(c_byp), .Wr_Count(cnt_byp)
    );

    reg_file16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut_nob (
        .clk(clk), .reset_n(reset_n), .W_En(W_En), .W_Addr(W_Addr),
        .W_Data(W_Data), .R_Addr(R_Addr), .S_Addr(S_Addr), .R(r_nob),
        .S(s_nob), .Flag_Ld(Flag_Ld), .N_in(N_in), .Z_in(Z_in),
        .C_in(C_in), .N(n_nob), .Z(z_nob), .C(c_nob), .Wr_Count(cnt_nob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // An unknown write address during an enabled write is illegal
    always @(posedge clk) begin
        if (reset_n === 1'b1 && W_En === 1'b1) begin
            assert (!$isunknown(W_Addr))
                else $error("[TB] unknown W_Addr during write");
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        mdl_n = 1'b0;
        mdl_z = 1'b0;
        mdl_c = 1'b0;
        mdl_cnt = 0;
    endtask

    // The rules applied at each rising edge
    task automatic modelEdge();
        if (reset_n) begin
            if (W_En) begin
                mdl[W_Addr] = W_Data;
                mdl_cnt = (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
            end
            if (Flag_Ld) begin
                mdl_n = N_in;
                mdl_z = Z_in;
                mdl_c = C_in;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [15:0] exp_r_byp, exp_s_byp;
        exp_r_byp = (W_En && W_Addr == R_Addr) ? W_Data : mdl[R_Addr];
        exp_s_byp = (W_En && W_Addr == S_Addr) ? W_Data : mdl[S_Addr];
        if (!reset_n) begin
            exp_r_byp = 16'h0000;
            exp_s_byp = 16'h0000;
        end
        checkOutput({tag, ".r_byp"}, {16'h0, r_byp}, {16'h0, exp_r_byp});
        checkOutput({tag, ".s_byp"}, {16'h0, s_byp}, {16'h0, exp_s_byp});
        checkOutput({tag, ".r_nob"}, {16'h0, r_nob}, {16'h0, mdl[R_Addr]});
        checkOutput({tag, ".s_nob"}, {16'h0, s_nob}, {16'h0, mdl[S_Addr]});
        checkOutput({tag, ".nzc_byp"}, {29'h0, n_byp, z_byp, c_byp},
                    {29'h0, mdl_n, mdl_z, mdl_c});
        checkOutput({tag, ".nzc_nob"}, {29'h0, n_nob, z_nob, c_nob},
                    {29'h0, mdl_n, mdl_z, mdl_c});
        checkOutput({tag, ".cnt_byp"}, {24'h0, cnt_byp}, mdl_cnt);
        checkOutput({tag, ".cnt_nob"}, {24'h0, cnt_nob}, mdl_cnt);
    endtask

    // Drive one cycle's inputs just after an edge, check the combinational
    // view mid-cycle, then take the edge and update the model.
    task automatic applyStimulus(input string tag, input logic we,
                                 input logic [2:0] wa, input logic [15:0] wd,
                                 input logic [2:0] ra, input logic [2:0] sa,
                                 input logic fl, input logic n,
                                 input logic z, input logic c);
        W_En = we;  W_Addr = wa;  W_Data = wd;
        R_Addr = ra; S_Addr = sa;
        Flag_Ld = fl; N_in = n; Z_in = z; C_in = c;
        #2;
        checkAll(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Assert reset mid-cycle with the current inputs left in place, hold it
    // across an edge, then release it away from the edge.
    task automatic doReset(input string tag);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkAll({tag, ".asserted"});
        @(posedge clk);
        #1;
        checkAll({tag, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        W_En = 1'b0; W_Addr = 3'd0; W_Data = 16'h0; R_Addr = 3'd0;
        S_Addr = 3'd0; Flag_Ld = 1'b0; N_in = 1'b0; Z_in = 1'b0; C_in = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("por");
        reset_n = 1'b1;

        // Reset in the middle of a pending write to register 3
        applyStimulus("pre_wr", 1'b1, 3'd6, 16'h1234, 3'd6, 3'd0,
                      1'b1, 1'b1, 1'b1, 1'b1);
        W_En = 1'b1; W_Addr = 3'd3; W_Data = 16'hBEEF;
        R_Addr = 3'd3; S_Addr = 3'd6;
        doReset("rst_mid");
        checkOutput("rst_r3_zero", {16'h0, r_byp}, 32'h0);
        applyStimulus("rst_rel", 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd6,
                      1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("rst_rd3", 1'b0, 3'd0, 16'h0, 3'd3, 3'd3,
                      1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_beef", {16'h0, r_nob}, 32'h0000BEEF);

        // Write every register, then read all of them back on both ports
        doReset("rst_wall");
        for (int k = 0; k < 8; k++) begin
            applyStimulus("wr_all", 1'b1, 3'(k), 16'(16'h1111 * k), 3'(k),
                          3'(7 - k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus("rd_all", 1'b0, 3'd0, 16'h0, 3'(k), 3'(7 - k),
                          1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("wr_all_cnt", {24'h0, cnt_byp}, 32'd8);

        // Forwarding onto both ports at once
        applyStimulus("byp_init", 1'b1, 3'd5, 16'h0005, 3'd0, 3'd0,
                      1'b0, 1'b0, 1'b0, 1'b0);
        W_En = 1'b1; W_Addr = 3'd5; W_Data = 16'hA5A5; R_Addr = 3'd5;
        S_Addr = 3'd5;
        #2;
        checkOutput("byp_r_on", {16'h0, r_byp}, 32'h0000A5A5);
        checkOutput("byp_s_on", {16'h0, s_byp}, 32'h0000A5A5);
        checkOutput("byp_r_off", {16'h0, r_nob}, 32'h00000005);
        applyStimulus("byp", 1'b1, 3'd5, 16'hA5A5, 3'd5, 3'd5,
                      1'b0, 1'b0, 1'b0, 1'b0);
        W_En = 1'b0;
        #2;
        checkOutput("byp_r_off_after", {16'h0, r_nob}, 32'h0000A5A5);

        // Load the flags, then hold them
        applyStimulus("flag_ld", 1'b0, 3'd0, 16'h0, 3'd0, 3'd1,
                      1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus("flag_hold", 1'b0, 3'd0, 16'h0, 3'd0, 3'd1,
                      1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("flag_hold_nzc", {29'h0, n_byp, z_byp, c_byp}, 32'd5);

        // Loop through the ALU: FFFF + 0001 gives 0000 with a carry
        applyStimulus("alu_r1", 1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd2,
                      1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("alu_r2", 1'b1, 3'd2, 16'h0001, 3'd1, 3'd2,
                      1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("alu_wb", 1'b1, 3'd3, 16'(r_nob + s_nob), 3'd1, 3'd2,
                      1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("alu_rd", 1'b0, 3'd0, 16'h0, 3'd3, 3'd3,
                      1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("alu_reg3", {16'h0, r_nob}, 32'h0);
        checkOutput("alu_nzc", {29'h0, n_nob, z_nob, c_nob}, 32'd3);

        // The write counter saturates
        for (int i = 0; i < 300; i++) begin
            applyStimulus("sat", 1'b1, 3'($urandom_range(0, 7)),
                          16'($urandom), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("sat_cnt", {24'h0, cnt_byp}, 32'd255);

        // Randomised mix, with an occasional mid-run reset
        doReset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset("rst_rand_mid");
            applyStimulus("rand", 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 16'($urandom),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
